// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential chunked magnitude comparator:
// FSM encoding and the helpers that size the chunk index.
`timescale 1ns/1ps
package cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Number of D-bit chunks in a W-bit operand.
   function automatic int nch(input int w, input int d);
      return w / d;
   endfunction

   // Width of the chunk index; never narrower than one bit.
   function automatic int idx_w(input int n);
      if (n <= 32'sd2) begin
         return 32'sd1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/cmp_seq_n_if.sv
// Start/operand/result bundle of the sequential comparator.
`timescale 1ns/1ps
interface cmp_seq_n_if #(
   parameter int W = 16
);
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         done_tick;
   logic         aeqb;
   logic         agtb;
   logic         altb;

   modport master (
      output start, a, b,
      input  ready, done_tick, aeqb, agtb, altb
   );

   modport slave (
      input  start, a, b,
      output ready, done_tick, aeqb, agtb, altb
   );
endinterface

// File: rtl/cmp_chunk.sv
// One-chunk magnitude compare. When msb_signed_i is set, the top bit of
// each chunk is inverted so a plain unsigned compare orders two's-complement
// values correctly.
`timescale 1ns/1ps
module cmp_chunk #(
   parameter int D = 2
) (
   input  logic [D-1:0] a_i,
   input  logic [D-1:0] b_i,
   input  logic         msb_signed_i,
   output logic         eq_o,
   output logic         gt_o
);
   logic [D-1:0] a_s;
   logic [D-1:0] b_s;

   // Bias the sign bit, then compare unsigned.
   always_comb begin
      a_s      = a_i;
      b_s      = b_i;
      a_s[D-1] = a_i[D-1] ^ msb_signed_i;
      b_s[D-1] = b_i[D-1] ^ msb_signed_i;
      eq_o     = (a_s == b_s);
      gt_o     = (a_s > b_s);
   end
endmodule

// File: rtl/cmp_seq_n.sv
// Multi-cycle W-bit magnitude comparator. Operands are captured on an
// accepted start and walked MSB-first, D bits per clock, stopping at the
// first chunk that differs. Results are held until the next completion.
`timescale 1ns/1ps
module cmp_seq_n
   import cmp_pkg::*;
#(
   parameter int W      = 16,
   parameter int D      = 2,
   parameter int SIGNED = 0
) (
   input logic        clk,
   input logic        reset,
   cmp_seq_n_if.slave bus
);
   localparam int            NCH     = nch(W, D);
   localparam int            IW      = idx_w(NCH);
   localparam logic [IW-1:0] IDX_TOP = IW'(NCH - 1);

   generate
      if ((D < 1) || (D > W) || ((W % D) != 0)) begin : g_bad_width
         $error("cmp_seq_n: W must be a positive multiple of D");
      end
   endgenerate

   state_t        state_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [IW-1:0] idx_q;
   logic [IW-1:0] idx_d;
   logic          ready_q;
   logic          done_q;
   logic          eq_q;
   logic          gt_q;
   logic          lt_q;

   logic [W-1:0]  sh_a_s;
   logic [W-1:0]  sh_b_s;
   logic [D-1:0]  ca_s;
   logic [D-1:0]  cb_s;
   logic          msb_sgn_s;
   logic          ch_eq_s;
   logic          ch_gt_s;

   // Select the current chunk; sign bias only applies to the MSB chunk.
   always_comb begin
      sh_a_s = a_q >> (D * idx_q);
      sh_b_s = b_q >> (D * idx_q);
      ca_s   = sh_a_s[D-1:0];
      cb_s   = sh_b_s[D-1:0];
      idx_d  = idx_q - IW'(1);
      if ((SIGNED != 0) && (idx_q == IDX_TOP)) begin
         msb_sgn_s = 1'b1;
      end else begin
         msb_sgn_s = 1'b0;
      end
   end

   cmp_chunk #(.D(D)) u_chunk (
      .a_i          (ca_s),
      .b_i          (cb_s),
      .msb_signed_i (msb_sgn_s),
      .eq_o         (ch_eq_s),
      .gt_o         (ch_gt_s)
   );

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         idx_q   <= IDX_TOP;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  idx_q   <= IDX_TOP;
                  ready_q <= 1'b0;
                  state_q <= ST_BUSY;
               end else begin
                  ready_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (!ch_eq_s) begin
                  eq_q    <= 1'b0;
                  gt_q    <= ch_gt_s;
                  lt_q    <= ~ch_gt_s;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= ST_DONE;
               end else if (idx_q == '0) begin
                  eq_q    <= 1'b1;
                  gt_q    <= 1'b0;
                  lt_q    <= 1'b0;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  idx_q <= idx_d;
               end
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready     = ready_q;
   assign bus.done_tick = done_q;
   assign bus.aeqb      = eq_q;
   assign bus.agtb      = gt_q;
   assign bus.altb      = lt_q;
endmodule
